// File: rtl/io_periph_bus_pkg.sv
// Shared IO map for the peripheral bus: word-select bits, CNTL field positions, UART states.
// The firmware headers carry the same constants.
package io_periph_bus_pkg;

    localparam int unsigned SEL_LEDS_BIT = 2;
    localparam int unsigned SEL_DATA_BIT = 3;
    localparam int unsigned SEL_CNTL_BIT = 4;

    localparam int unsigned CNTL_BUSY_BIT  = 0;
    localparam int unsigned CNTL_FULL_BIT  = 1;
    localparam int unsigned CNTL_EMPTY_BIT = 2;
    localparam int unsigned CNTL_OVF_BIT   = 3;
    localparam int unsigned CNTL_COUNT_LSB = 4;
    localparam int unsigned CNTL_COUNT_MSB = 7;

    localparam int unsigned UART_BITS = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/io_periph_bus_uart_tx.sv
// 8N1 UART transmit serializer: baud counter, bit index and shift register.
// Accepts a new byte in IDLE or on the last stop-bit cycle so frames run back-to-back.
module uart_tx_serializer
    import io_periph_bus_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready_c,
    output logic       uart_tx,
    output logic       busy_c
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BAUD_DIV - 1);
    localparam logic [2:0] LAST_BIT = 3'(UART_BITS - 1);

    tx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             baud_done;

    assign baud_done  = (cnt == '0);
    assign in_ready_c = (state == TX_IDLE) || ((state == TX_STOP) && baud_done);
    assign busy_c     = (state != TX_IDLE);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= TX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            uart_tx <= 1'b1;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (in_valid) begin
                        state   <= TX_START;
                        shift   <= in_data;
                        uart_tx <= 1'b0;
                        cnt     <= RELOAD;
                    end
                end
                TX_START: begin
                    if (baud_done) begin
                        state   <= TX_DATA;
                        uart_tx <= shift[0];
                        bit_idx <= '0;
                        cnt     <= RELOAD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (baud_done) begin
                        cnt   <= RELOAD;
                        shift <= shift >> 1;
                        if (bit_idx == LAST_BIT) begin
                            state   <= TX_STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            uart_tx <= shift[1];
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (baud_done) begin
                        // Chain straight into the next start bit when a byte is waiting.
                        if (in_valid) begin
                            state   <= TX_START;
                            shift   <= in_data;
                            uart_tx <= 1'b0;
                            cnt     <= RELOAD;
                        end else begin
                            state <= TX_IDLE;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/io_periph_bus.sv
// Memory-mapped IO responder: one-hot word decode, LED register, UART TX FIFO and CNTL status.
// Read data is combinational because the core samples it at the edge that ends M.
module io_periph_bus
    import io_periph_bus_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = 434,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LED_WIDTH  = 5
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [31:0]          IO_mem_addr,
    input  logic [31:0]          IO_mem_wdata,
    input  logic                 IO_mem_wr,
    output logic [31:0]          IO_mem_rdata,
    output logic [LED_WIDTH-1:0] leds,
    output logic                 uart_tx
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic             sel_leds, sel_data, sel_cntl;
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             full, empty;
    logic             push_req, push_ok, pop, ovf_set, ovf_clr;
    logic             ser_ready_c, ser_busy_c;
    logic [31:0]      cntl_word;
    logic             unused_bits;

    assign sel_leds = IO_mem_addr[SEL_LEDS_BIT];
    assign sel_data = IO_mem_addr[SEL_DATA_BIT];
    assign sel_cntl = IO_mem_addr[SEL_CNTL_BIT];
    assign unused_bits = ^{IO_mem_addr, IO_mem_wdata};

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // A push into a full FIFO survives only when the serializer frees a slot on the same edge.
    assign pop      = ser_ready_c && !empty;
    assign push_req = IO_mem_wr && sel_data;
    assign push_ok  = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;
    assign ovf_clr  = IO_mem_wr && sel_cntl && IO_mem_wdata[CNTL_OVF_BIT];

    always_comb begin
        cntl_word = '0;
        cntl_word[CNTL_BUSY_BIT]  = ser_busy_c;
        cntl_word[CNTL_FULL_BIT]  = full;
        cntl_word[CNTL_EMPTY_BIT] = empty;
        cntl_word[CNTL_OVF_BIT]   = overflow;
        cntl_word[CNTL_COUNT_MSB:CNTL_COUNT_LSB] = 4'(count);
    end

    // Overlapping selects read back as the OR of every selected register; DATA reads 0.
    always_comb begin
        IO_mem_rdata = '0;
        if (sel_leds) IO_mem_rdata = IO_mem_rdata | 32'(leds);
        if (sel_cntl) IO_mem_rdata = IO_mem_rdata | cntl_word;
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= IO_mem_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            leds     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (IO_mem_wr && sel_leds) leds <= IO_mem_wdata[LED_WIDTH-1:0];
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop);
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    uart_tx_serializer #(
        .BAUD_DIV (BAUD_DIV)
    ) u_ser (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (!empty),
        .in_data    (fifo_mem[rd_ptr]),
        .in_ready_c (ser_ready_c),
        .uart_tx    (uart_tx),
        .busy_c     (ser_busy_c)
    );

endmodule

// File: doc/io_periph_bus.md
Name: io_periph_bus

Overview:
- Responder for the core's memory-mapped IO port (IO_mem_addr / IO_mem_wdata / IO_mem_wr / IO_mem_rdata).
- Decodes one-hot word-select address bits and holds an LED register.
- Contains a UART transmit path: FIFO, 8N1 serializer, and status/control register.
- Sits beside the data RAM at SoC top level; software polls status, because the core has no IO wait/stall.

Parameters:
- BAUD_DIV, 434, clk cycles per UART bit (50 MHz / 115200); must be >= 2.
- FIFO_DEPTH, 4, TX FIFO entries; must be a power of 2, >= 2.
- LED_WIDTH, 5, width of the LED output register.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- IO_mem_addr  in  32  byte address from the core's M stage; presented every cycle.
- IO_mem_wdata  in  32  store data; valid when IO_mem_wr=1.
- IO_mem_wr  in  1  single-cycle store strobe; already qualified by address bit 22.
- IO_mem_rdata  out  32  read data, combinational from IO_mem_addr and current register state.
- leds  out  LED_WIDTH  LED register.
- uart_tx  out  1  serial line; idles high.

Behaviour:
- Select lines: sel_leds=IO_mem_addr[2], sel_data=IO_mem_addr[3], sel_cntl=IO_mem_addr[4].
  - Bit 22 is not decoded here.
  - Several selects at once: a write goes to every selected register; a read returns the bitwise OR of the selected values.
- Read timing: IO_mem_rdata is purely combinational, because the core samples it at the edge that ends M.
- Read values:
  - LEDS: {zero-extended leds}.
  - DATA: reads 0.
  - CNTL: {24'b0, count[3:0] zero-extended, overflow, empty, full, busy} at bits [7:4],3,2,1,0.
  - No address selected: IO_mem_rdata=0.
- LEDS write: at the IO_mem_wr edge, leds <= IO_mem_wdata[LED_WIDTH-1:0].
- DATA write: pushes IO_mem_wdata[7:0] into the FIFO at that edge.
  - FIFO full with no pop that edge: byte dropped, overflow <= 1 (sticky).
  - FIFO full with a pop that edge: push is accepted and count is unchanged.
- CNTL write with IO_mem_wdata[3]=1: clears overflow. If an overflow event occurs on the same edge, set wins.
- FIFO: circular buffer with pointers that wrap modulo FIFO_DEPTH, plus count (0..FIFO_DEPTH).
  - full = count==FIFO_DEPTH; empty = count==0.
  - Simultaneous push and pop on non-full: count unchanged, data order preserved.
- Serializer state machine: IDLE, START, DATA, STOP.
  - Baud counter runs BAUD_DIV-1 down to 0; bit index 0..7; 8-bit shift register.
  - IDLE & !empty -> START: pop FIFO, load shift register, uart_tx <= 0, counter reload.
  - START, counter==0 -> DATA: uart_tx <= shift[0], bit index 0.
  - DATA, counter==0: shift right. Bit index <7: next bit. Bit index ==7: -> STOP, uart_tx <= 1.
  - STOP, counter==0: if !empty -> START directly (pop, tx <= 0, no idle gap); else -> IDLE.
  - busy = (state != IDLE).
- Frame timing: write at edge E0 makes uart_tx fall at E0+1.
  - Start bit lasts BAUD_DIV cycles, LSB first.
  - Stop bit spans E0+1+9*BAUD_DIV to E0+1+10*BAUD_DIV.
  - Back-to-back frames are exactly 10*BAUD_DIV cycles apart.
- uart_tx is registered, so it is glitch-free.
- Reset (synchronous, any state, including mid-frame) sets, at the reset edge:
  - leds=0, uart_tx=1, state IDLE;
  - FIFO empty (pointers 0, count 0), overflow=0, counters 0.
- Writes while resetn=0 are ignored.

Decomposition:
- Shared include io_map.vh holds:
  - word-select bit indices (LEDS=2, DATA=3, CNTL=4);
  - CNTL field bit positions (BUSY=0, FULL=1, EMPTY=2, OVF=3, COUNT=7:4);
  - state encodings IDLE=0, START=1, DATA=2, STOP=3.
- The core's firmware headers use the same constants.
- One sub-module, uart_tx_serializer, contains the state machine, baud counter and shift register.
  - Interface: valid/ready byte input (ready = in IDLE, or in STOP with counter==0), uart_tx, busy.
  - FIFO, decode and readback stay in io_periph_bus.

Test Plan (BAUD_DIV=4, FIFO_DEPTH=4, LED_WIDTH=5):
- Reset, then hold: uart_tx=1, leds=0, CNTL read = 0x00000004 (empty only).
- Write 0x1F to LEDS, then read LEDS: leds=5'h1F and readback 0x1F; IO_mem_wdata=0xFFFFFFE0 -> leds=0.
- Write 0xA5 to DATA at E0: uart_tx low for E0+1..E0+4; data bits 1,0,1,0,0,1,0,1 at 4 cycles each; high from E0+37; busy=0 after E0+41.
- Write 6 bytes on consecutive cycles: first pops immediately, 4 queue, sixth dropped, CNTL bit3=1. Five frames go out back-to-back at 40-cycle spacing with no idle between stop and start; CNTL write 0x8 clears overflow.
- Push on the exact edge STOP->START pops with FIFO full: no overflow; count remains 4; byte order preserved.
- Assert resetn=0 mid-DATA bit 3 for one cycle: uart_tx=1 at that edge, FIFO empty, overflow=0; a new DATA write afterwards produces a clean frame.
